// File: rtl/alu_req_arbiter_if.sv
// Request, response and arithmetic-unit signal bundle
// for the two-port arbiter.
interface alu_req_arbiter_if #(
  parameter int DATA_W = 16
);
  logic              req0_valid;
  logic              req0_ready;
  logic [1:0]        req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [1:0]        req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [2*DATA_W-1:0] rsp_data;
  logic                rsp_ovf;
  logic                rsp_dz;

  logic [DATA_W-1:0]   alu_A;
  logic [DATA_W-1:0]   alu_B;
  logic [3:0]          alu_fun;
  logic                alu_en;
  logic [2*DATA_W-1:0] alu_out;
  logic                alu_flag;
  logic                alu_ovf;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data,
    output rsp_ovf, rsp_dz,
    input  rsp_ready,
    output alu_A, alu_B, alu_fun, alu_en,
    input  alu_out, alu_flag, alu_ovf
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data,
    input  rsp_ovf, rsp_dz,
    output rsp_ready,
    input  alu_A, alu_B, alu_fun, alu_en,
    output alu_out, alu_flag, alu_ovf
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter/sequencer feeding the shared
// arithmetic unit; one operation in flight at a time.
module alu_req_arbiter #(
  parameter int DATA_W = 16
) (
  input logic CLK_in,
  input logic RST_in,
  alu_req_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_last;
  logic [1:0]        r_op;
  logic              r_dz;
  logic              r_id;
  logic              w_g;
  logic              w_acc;
  logic [1:0]        w_op;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;

  // Tie goes to whoever did not win last time.
  assign w_g = (bus.req0_valid && bus.req1_valid)
             ? ~r_last : bus.req1_valid;
  assign w_op = w_g ? bus.req1_op : bus.req0_op;
  assign w_a  = w_g ? bus.req1_a  : bus.req0_a;
  assign w_b  = w_g ? bus.req1_b  : bus.req0_b;

  always_comb begin
    w_next = r_state;
    w_acc  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_acc = (bus.req0_valid || bus.req1_valid)
              && !RST_in;
        if (w_acc) w_next = ISSUE;
      end
      ISSUE: w_next = WAIT;
      WAIT: if (bus.alu_flag) w_next = RESP;
      RESP: if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    bus.req0_ready = w_acc && !w_g;
    bus.req1_ready = w_acc && w_g;
  end

  always_ff @(posedge CLK_in) begin
    if (RST_in) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge CLK_in) begin
    if (RST_in) begin
      r_last      <= 1'b1;
      r_op        <= 2'd0;
      r_dz        <= 1'b0;
      r_id        <= 1'b0;
      bus.alu_en  <= 1'b0;
      bus.alu_A   <= '0;
      bus.alu_B   <= '0;
      bus.alu_fun <= 4'd0;
    end else begin
      // Unit inputs are live only during ISSUE.
      bus.alu_en  <= w_acc;
      bus.alu_A   <= w_acc ? w_a : '0;
      bus.alu_B   <= w_acc ? w_b : '0;
      bus.alu_fun <= w_acc ? {2'b00, w_op} : 4'd0;
      if (w_acc) begin
        r_op   <= w_op;
        r_dz   <= (w_op == 2'b11) && (w_b == '0);
        r_id   <= w_g;
        r_last <= w_g;
      end
    end
  end

  always_ff @(posedge CLK_in) begin
    if (RST_in) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_data  <= '0;
      bus.rsp_ovf   <= 1'b0;
      bus.rsp_dz    <= 1'b0;
    end else begin
      bus.rsp_valid <= (w_next == RESP);
      if (r_state == WAIT && bus.alu_flag) begin
        bus.rsp_id   <= r_id;
        bus.rsp_data <= bus.alu_out;
        bus.rsp_ovf  <= (r_op == 2'b11)
                      ? 1'b0 : bus.alu_ovf;
        bus.rsp_dz   <= r_dz;
      end
    end
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a behavioural
// arithmetic unit and a response scoreboard.
module tb_alu_req_arbiter;
  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        ovf;
    logic        dz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  exp_t sb[$];
  exp_t rl[$];
  int   gl[$];
  int   al[$];

  alu_req_arbiter_if #(.DATA_W(16)) bus ();

  alu_req_arbiter #(.DATA_W(16)) dut (
    .CLK_in (clk),
    .RST_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unit model: ovf on 16-bit add/sub overflow,
  // and a spurious ovf on div.
  function automatic logic [32:0] unit_calc(
    input logic [1:0] op,
    input logic [15:0] a,
    input logic [15:0] b);
    logic signed [31:0] sa, sbv, r;
    logic ov;
    sa  = {{16{a[15]}}, a};
    sbv = {{16{b[15]}}, b};
    ov  = 1'b0;
    case (op)
      2'd0: begin
        r  = sa + sbv;
        ov = (r > 32767) || (r < -32768);
      end
      2'd1: begin
        r  = sa - sbv;
        ov = (r > 32767) || (r < -32768);
      end
      2'd2: r = sa * sbv;
      default: begin
        r  = (b == 16'd0) ? 32'sd0 : sa / sbv;
        ov = 1'b1;
      end
    endcase
    return {ov, r};
  endfunction

  always @(posedge clk) begin
    bus.alu_flag <= bus.alu_en;
    if (bus.alu_en)
      {bus.alu_ovf, bus.alu_out} <=
        unit_calc(bus.alu_fun[1:0], bus.alu_A,
                  bus.alu_B);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic id,
                              input logic [1:0] op,
                              input logic [15:0] a,
                              input logic [15:0] b);
    exp_t e;
    logic [32:0] u;
    u      = unit_calc(op, a, b);
    e.id   = id;
    e.data = u[31:0];
    e.ovf  = (op == 2'd3) ? 1'b0 : u[32];
    e.dz   = (op == 2'd3) && (b == 16'd0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.req0_valid && bus.req0_ready) begin
      sb.push_back(mk(1'b0, bus.req0_op,
                      bus.req0_a, bus.req0_b));
      gl.push_back(0);
      al.push_back(cyc);
      chk("one_grant", {31'd0, bus.req1_ready}, 0);
    end
    if (bus.req1_valid && bus.req1_ready) begin
      sb.push_back(mk(1'b1, bus.req1_op,
                      bus.req1_a, bus.req1_b));
      gl.push_back(1);
      al.push_back(cyc);
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_id", {31'd0, bus.rsp_id}, {31'd0, e.id});
        chk("sb_data", bus.rsp_data, e.data);
        chk("sb_ovf", {31'd0, bus.rsp_ovf},
            {31'd0, e.ovf});
        chk("sb_dz", {31'd0, bus.rsp_dz},
            {31'd0, e.dz});
      end
      rl.push_back('{bus.rsp_id, bus.rsp_data,
                     bus.rsp_ovf, bus.rsp_dz});
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int p,
                     input logic v,
                     input logic [1:0] op,
                     input logic [15:0] a,
                     input logic [15:0] b);
    if (p == 0) begin
      bus.req0_valid = v; bus.req0_op = op;
      bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op;
      bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!bus.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, bus.rsp_valid}, 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || bus.rsp_valid)
           && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb.size(), 0);
    nxt();
  endtask

  task automatic chk_last(input string tag,
                          input logic id,
                          input logic [31:0] d,
                          input logic ovf,
                          input logic dz);
    if (rl.size() == 0) begin
      chk({tag, "_none"}, 0, 1);
    end else begin
      chk({tag, "_id"}, {31'd0, rl[$].id}, {31'd0, id});
      chk({tag, "_data"}, rl[$].data, d);
      chk({tag, "_ovf"}, {31'd0, rl[$].ovf},
          {31'd0, ovf});
      chk({tag, "_dz"}, {31'd0, rl[$].dz}, {31'd0, dz});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    drv(0, 1'b1, 2'd0, 16'd1, 16'd2);
    drv(1, 1'b1, 2'd0, 16'd3, 16'd4);
    repeat (2) @(negedge clk);
    chk("rst_rdy0", {31'd0, bus.req0_ready}, 0);
    chk("rst_rdy1", {31'd0, bus.req1_ready}, 0);
    chk("rst_rspv", {31'd0, bus.rsp_valid}, 0);
    chk("rst_en", {31'd0, bus.alu_en}, 0);
    chk("rst_A", {16'd0, bus.alu_A}, 0);
    chk("rst_fun", {28'd0, bus.alu_fun}, 0);
    chk("rst_data", bus.rsp_data, 0);
    chk("rst_id", {31'd0, bus.rsp_id}, 0);
    nxt();
    drv(0, 1'b0, 2'd0, 16'd0, 16'd0);
    drv(1, 1'b0, 2'd0, 16'd0, 16'd0);
    rst = 1'b0;
    nxt();

    // Contention: both valid, grants must alternate.
    drv(0, 1'b1, 2'd2, 16'd7, -16'sd3);
    drv(1, 1'b1, 2'd1, 16'd5, 16'd9);
    repeat (17) nxt();
    drv(0, 1'b0, 2'd0, 16'd0, 16'd0);
    drv(1, 1'b0, 2'd0, 16'd0, 16'd0);
    drain("drain_cont");
    chk("cont_ngrant", {31'd0, gl.size() >= 4}, 1);
    if (gl.size() >= 4 && rl.size() >= 2) begin
      chk("cont_g0", gl[0], 0);
      chk("cont_g1", gl[1], 1);
      chk("cont_g2", gl[2], 0);
      chk("cont_g3", gl[3], 1);
      chk("cont_space", al[1] - al[0], 4);
      chk("cont_d0", rl[0].data, 32'hFFFF_FFEB);
      chk("cont_d1", rl[1].data, 32'hFFFF_FFFC);
      chk("cont_i1", {31'd0, rl[1].id}, 1);
    end

    // Single add with latency and unit-input timing.
    drv(0, 1'b1, 2'd0, 16'd100, 16'd23);
    @(negedge clk);
    chk("add_rdy0", {31'd0, bus.req0_ready}, 1);
    chk("add_rdy1", {31'd0, bus.req1_ready}, 0);
    nxt();
    drv(0, 1'b0, 2'd0, 16'd0, 16'd0);
    @(negedge clk);
    chk("iss_en", {31'd0, bus.alu_en}, 1);
    chk("iss_A", {16'd0, bus.alu_A}, 100);
    chk("iss_B", {16'd0, bus.alu_B}, 23);
    chk("iss_fun", {28'd0, bus.alu_fun}, 0);
    nxt();
    @(negedge clk);
    chk("wait_en", {31'd0, bus.alu_en}, 0);
    chk("wait_A", {16'd0, bus.alu_A}, 0);
    wait_rsp("add_rsp");
    chk("add_lat", cyc - al[$], 3);
    chk("add_data", bus.rsp_data, 123);
    chk("add_id", {31'd0, bus.rsp_id}, 0);
    @(negedge clk);
    chk("add_drop", {31'd0, bus.rsp_valid}, 0);
    nxt();

    // Add overflow passes through.
    drv(0, 1'b1, 2'd0, 16'h7FFF, 16'd1);
    nxt();
    drv(0, 1'b0, 2'd0, 16'd0, 16'd0);
    drain("drain_ovf");
    chk_last("ovf", 1'b0, 32'd32768, 1'b1, 1'b0);

    // Divide by zero from req1.
    drv(1, 1'b1, 2'd3, 16'd50, 16'd0);
    @(negedge clk);
    chk("dz_rdy1", {31'd0, bus.req1_ready}, 1);
    nxt();
    drv(1, 1'b0, 2'd0, 16'd0, 16'd0);
    drain("drain_dz");
    chk_last("dz", 1'b1, 32'd0, 1'b0, 1'b1);

    // Signed divide.
    drv(0, 1'b1, 2'd3, -16'sd100, 16'd7);
    nxt();
    drv(0, 1'b0, 2'd0, 16'd0, 16'd0);
    drain("drain_div");
    chk_last("div", 1'b0, 32'hFFFF_FFF2, 1'b0, 1'b0);

    // Backpressure on the response channel.
    bus.rsp_ready = 1'b0;
    drv(0, 1'b1, 2'd0, 16'd1, 16'd2);
    nxt();
    drv(0, 1'b1, 2'd0, 16'd3, 16'd4);
    @(negedge clk);
    wait_rsp("bp_rsp");
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", {31'd0, bus.rsp_valid}, 1);
      chk("bp_data", bus.rsp_data, 3);
      chk("bp_rdy0", {31'd0, bus.req0_ready}, 0);
      @(negedge clk);
    end
    nxt();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_rdy0", {31'd0, bus.req0_ready}, 0);
    nxt();
    @(negedge clk);
    chk("bp_idle_rdy0", {31'd0, bus.req0_ready}, 1);
    nxt();
    drv(0, 1'b0, 2'd0, 16'd0, 16'd0);
    drain("drain_bp");
    chk_last("bp2", 1'b0, 32'd7, 1'b0, 1'b0);

    // Reset during WAIT discards the operation.
    drv(0, 1'b1, 2'd0, 16'd5, 16'd6);
    @(negedge clk);
    chk("rw_rdy0", {31'd0, bus.req0_ready}, 1);
    nxt();
    drv(0, 1'b0, 2'd0, 16'd0, 16'd0);
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("rw_data", bus.rsp_data, 0);
    chk("rw_en", {31'd0, bus.alu_en}, 0);
    for (int i = 0; i < 5; i++) begin
      chk("rw_novalid", {31'd0, bus.rsp_valid}, 0);
      @(negedge clk);
    end
    nxt();
    drv(0, 1'b1, 2'd0, 16'd1, 16'd1);
    drv(1, 1'b1, 2'd0, 16'd2, 16'd2);
    @(negedge clk);
    chk("rw_tie0", {31'd0, bus.req0_ready}, 1);
    chk("rw_tie1", {31'd0, bus.req1_ready}, 0);
    nxt();
    drv(0, 1'b0, 2'd0, 16'd0, 16'd0);
    drv(1, 1'b0, 2'd0, 16'd0, 16'd0);
    drain("drain_rw");
    chk_last("rw_after", 1'b0, 32'd2, 1'b0, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Two-port round-robin arbiter and sequencer for the shared arithmetic unit. It accepts operation requests from two independent requesters over valid/ready handshakes and grants one at a time. It drives the unit's operand, function and enable inputs, waits for the unit's registered result, then returns the result with a requester ID over a single valid/ready response channel. The block sits between the requesting masters and the arithmetic unit. It owns all of the unit's datapath inputs except the unit's own clock and reset.

## Interface
- DATA_W, 16, operand width; results are 2*DATA_W wide.
- CLK_in  in  1  single clock, rising edge.
- RST_in  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational).
- req0_op / req1_op  in  2  00 add, 01 sub, 10 mul, 11 div.
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  signed operands.
- rsp_valid  out  1  response held until accepted.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester that owns the response (0/1).
- rsp_data  out  2*DATA_W  result.
- rsp_ovf  out  1  unit overflow flag; forced 0 for div.
- rsp_dz  out  1  divide-by-zero: op 11 with b == 0.
- alu_A, alu_B  out  DATA_W  operands to the unit (registered).
- alu_fun  out  4  {2'b00, op} (registered).
- alu_en  out  1  unit enable (registered).
- alu_out  in  2*DATA_W  unit result.
- alu_flag  in  1  unit result-valid flag.
- alu_ovf  in  1  unit overflow.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE
  - Grant is computed combinationally. If only one req_valid is high, grant that requester.
  - If both are high, grant the requester that is not last_grant.
  - req<g>_ready = 1 for the granted requester only.
  - On handshake: latch op/a/b, set id = g, set last_grant = g, compute dz = (op == 11 && b == 0), go to ISSUE.
- ISSUE: one cycle. alu_en = 1 and alu_A/alu_B/alu_fun driven from the latched request. Go to WAIT.
- WAIT
  - alu_en = 0 and alu_A/alu_B/alu_fun = 0.
  - When alu_flag = 1: capture alu_out into rsp_data, capture rsp_ovf = (op == 11) ? 0 : alu_ovf, capture rsp_dz = dz, go to RESP.
  - If alu_flag = 0, remain in WAIT. There is no timeout.
- RESP
  - rsp_valid = 1. rsp_id, rsp_data, rsp_ovf and rsp_dz are stable.
  - On rsp_valid && rsp_ready, go to IDLE. rsp_valid drops the next cycle.
- Requests are never accepted outside IDLE. Only one operation is in flight.
- Divide by zero is still issued. The unit returns 0 and rsp_dz = 1.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…

## Timing
- Reset values: state IDLE, last_grant = 1 (req0 wins the first tie), alu_en = 0, alu_A = alu_B = 0, alu_fun = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_ovf = 0, rsp_dz = 0, req*_ready = 0 while RST_in = 1.
- Handshake in cycle N:
  - ISSUE in N+1.
  - Unit registers its result at the end of N+1; alu_flag = 1 in N+2 (WAIT).
  - rsp_valid = 1 from N+3.
- Minimum accept-to-accept spacing is 4 cycles: RESP with rsp_ready = 1 returns to IDLE, and the next accept can occur in that IDLE cycle.
- rsp_ready held low keeps RESP indefinitely with all response outputs frozen. Pending requests wait with ready = 0.
- A requester may drop valid before a grant with no effect. Operands are sampled only on the handshake cycle.
- RST_in asserted in any state:
  - The in-flight operation is discarded. Next cycle the FSM is in IDLE with all outputs at reset values.
  - A stale alu_flag seen after reset is ignored, because it is only sampled in WAIT.
- Simultaneous req valid and RST_in: reset wins, no accept.

## Test plan
- Single add: req0 op 00, a = 100, b = 23 -> rsp_valid 3 cycles after accept, rsp_data = 123, rsp_id = 0, ovf = 0, dz = 0.
- Contention: req0 and req1 both valid continuously (req0 mul 7×-3, req1 sub 5-9) -> grant order 0,1,0,1; rsp_data -21 then -4 (sign-extended to 32 bits); ids alternate.
- Divide by zero: req1 op 11, a = 50, b = 0 -> rsp_data = 0, rsp_dz = 1, rsp_ovf = 0, rsp_id = 1.
- Backpressure: rsp_ready low for 10 cycles in RESP -> rsp_valid and rsp_data stable; req0_ready = 0 throughout; accept occurs in the IDLE cycle after rsp_ready rises.
- Reset mid-operation: assert RST_in for 1 cycle during WAIT -> next cycle IDLE, rsp_valid never asserts for that op, last_grant = 1, and the following tie grants req0.
- Signed div: a = -100, b = 7 -> rsp_data = -14, dz = 0, ovf = 0.
